writeback_coalesce_arb: RTL

WRITEBACK_COALESCE_ARB -- requirements
Module: writeback_coalesce_arb

---
 rtl/writeback_coalesce_arb_pkg.sv | 25 ++
 rtl/writeback_coalesce_arb_rr_arbiter.sv | 49 ++++
 rtl/writeback_coalesce_arb.sv | 96 +++++++++
 3 files changed

// File: rtl/writeback_coalesce_arb_pkg.sv
// Shared definitions for the writeback coalescing arbiter: channel names,
// default sizing and the index-width helper.
package writeback_coalesce_arb_pkg;

  localparam int WB_NUM_CH_DEFAULT     = 10;
  localparam int WB_DATA_WIDTH_DEFAULT = 40;

  typedef enum logic [3:0] {
    CQHEAD         = 4'd0,
    SQPSN          = 4'd1,
    LSTRQREQ       = 4'd2,
    INSRRPKTCNT    = 4'd3,
    INAMPKTCNT     = 4'd4,
    INNCKPKTSTS    = 4'd5,
    OUTAMPKTCNT    = 4'd6,
    OUTNAKPKTCNT   = 4'd7,
    OUTIOPKTCNT    = 4'd8,
    OUTRDRSPPKTCNT = 4'd9
  } wb_ch_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_coalesce_arb_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted requester and
// wraps; the pointer only moves when a grant is actually taken.
module rr_arbiter
  import writeback_coalesce_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             update_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic             found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_q) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign last_d = (update_i && found) ? idx_o : last_q;

  // Reset points at the top channel so channel 0 wins the first search.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IDX_W'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/writeback_coalesce_arb.sv
// Per-channel one-entry writeback slots (latest value wins) drained through a
// round-robin arbiter into a single valid/ready output register.
module writeback_coalesce_arb
  import writeback_coalesce_arb_pkg::*;
#(
  parameter  int NUM_CH     = WB_NUM_CH_DEFAULT,
  parameter  int DATA_WIDTH = WB_DATA_WIDTH_DEFAULT,
  localparam int CH_IDX_W   = idx_width(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CH_IDX_W-1:0]          out_ch_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [NUM_CH-1:0]            pending_o,
  output logic [NUM_CH-1:0]            coalesced_o,
  input  logic                         clear_i
);

  logic [DATA_WIDTH-1:0] slot_q [NUM_CH];
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0]     coalesced_q, coalesced_d;
  logic [NUM_CH-1:0]     gnt;
  logic [NUM_CH-1:0]     granted;
  logic [CH_IDX_W-1:0]   gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  out_free;
  logic                  grant_fire;
  logic                  out_valid_q;
  logic [CH_IDX_W-1:0]   out_ch_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  assign out_free   = !out_valid_q || out_ready_i;
  assign grant_fire = out_free && (|pending_q);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (pending_q),
    .update_i (out_free),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx)
  );

  // A write landing on the slot being granted stays pending and is not a
  // coalesce: the old value is the one leaving through the output.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign granted[gi]     = grant_fire & gnt[gi];
      assign pending_d[gi]   = in_valid_i[gi] | (pending_q[gi] & ~granted[gi]);
      assign coalesced_d[gi] = (in_valid_i[gi] & pending_q[gi] & ~granted[gi])
                             | (coalesced_q[gi] & ~clear_i);
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) gnt_data = slot_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      coalesced_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) slot_q[k] <= '0;
    end else begin
      pending_q   <= pending_d;
      coalesced_q <= coalesced_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (in_valid_i[k]) slot_q[k] <= in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant_fire) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= gnt_idx;
        out_data_q  <= gnt_data;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_data_o  = out_data_q;
  assign pending_o   = pending_q;
  assign coalesced_o = coalesced_q;

endmodule
